// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - EX-stage ALU with iterative shift-add multiplier and pipeline stall
module alu_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             stall_o,
  output logic             busy_o
);

  localparam logic [2:0] ALUCtrl_AND = 3'b000;
  localparam logic [2:0] ALUCtrl_OR  = 3'b001;
  localparam logic [2:0] ALUCtrl_ADD = 3'b010;
  localparam logic [2:0] ALUCtrl_MUL = 3'b011;
  localparam logic [2:0] ALUCtrl_SUB = 3'b110;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic [WIDTH-1:0] alu_result;
  logic             is_mul;
  logic             b_zero;

  assign is_mul = (ALUCtrl_i == ALUCtrl_MUL);
  assign b_zero = (data2_i == '0);

  // MUL with a zero multiplier falls into the default arm and yields 0
  always_comb begin
    alu_result = '0;
    case (ALUCtrl_i)
      ALUCtrl_AND: alu_result = data1_i & data2_i;
      ALUCtrl_OR:  alu_result = data1_i | data2_i;
      ALUCtrl_ADD: alu_result = data1_i + data2_i;
      ALUCtrl_SUB: alu_result = data1_i - data2_i;
      default:     alu_result = '0;
    endcase
  end

  assign acc_next    = mplier[0] ? (acc + mcand) : acc;
  assign mplier_next = mplier >> 1;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      data_o <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (is_mul && !b_zero) begin
              acc    <= '0;
              mcand  <= data1_i;
              mplier <= data2_i;
              state  <= S_RUN;
            end else begin
              data_o <= alu_result;
              state  <= S_DONE;
            end
          end
        end
        S_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          // early-out once no set multiplier bits remain
          if (mplier_next == '0) begin
            data_o <= acc_next;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = (state == S_RUN);
  assign valid_o = (state == S_DONE) && rst_i && !flush_i;
  assign stall_o = rst_i && !flush_i &&
                   (((state == S_IDLE) && start_i && is_mul && !b_zero) || (state == S_RUN));

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle execution unit controller in the EX stage. It executes single-cycle ALU operations in one registered cycle. For `ALUCtrl_MUL` it runs an iterative radix-2 shift-add sequence, with early termination, over several cycles. While a multiply is in flight it stalls the pipeline through `stall_o`. It consumes the 3-bit ALU control code produced by the ALU control decoder, using the `ALUCtrl_*` encodings from `opcodes.vh`.

## Interface
- `WIDTH`, 32, operand and result width; product is truncated to the low `WIDTH` bits (RISC-V MUL semantics)
- `clk_i`  input  1  clock; all state updates on rising edge
- `rst_i`  input  1  synchronous, active-low reset
- `start_i`  input  1  EX stage holds a valid instruction for this unit
- `flush_i`  input  1  abort in-flight operation (branch/exception flush)
- `ALUCtrl_i`  input  3  operation code (`ALUCtrl_OR/AND/ADD/SUB/MUL`)
- `data1_i`  input  WIDTH  operand A (multiplicand)
- `data2_i`  input  WIDTH  operand B (multiplier)
- `data_o`  output  WIDTH  registered result; holds last value between results
- `valid_o`  output  1  one-cycle pulse: `data_o` carries a new result
- `stall_o`  output  1  combinational pipeline stall request
- `busy_o`  output  1  registered; high while state is RUN

## Operation
- FSM states:
  - **IDLE**
    - `start_i` with a non-MUL code → compute the result and go to DONE.
    - `start_i` with MUL and `data2_i == 0` → result 0, go to DONE.
    - `start_i` with MUL and `data2_i != 0` → latch the operands and go to RUN.
  - **RUN**: one multiplier bit per cycle (see Step below).
  - **DONE**: `valid_o = 1` for exactly one cycle, then unconditionally IDLE.
- Operand latch on entering RUN: `acc = 0`, `mcand = data1_i`, `mplier = data2_i`.
- Step, in RUN, each edge:
  - if `mplier[0]`: `acc <= acc + mcand` (mod 2^WIDTH)
  - `mcand <= mcand << 1`
  - `mplier <= mplier >> 1`
  - if `(mplier >> 1) == 0`, go to DONE with `data_o <= ` the updated `acc`.
- Non-MUL results, all mod 2^WIDTH: OR = `A|B`, AND = `A&B`, ADD = `A+B`, SUB = `A-B`. Any undefined code → result 0, and `valid_o` still pulses.
- `stall_o`:
  - high when IDLE & `start_i` & MUL & `data2_i != 0`, or when state is RUN
  - low in DONE (pipeline captures `data_o` at the end of DONE)
  - low while `flush_i` is high
- `start_i` is ignored in RUN and DONE. Upstream holds the same instruction while stalled and during DONE.
- `flush_i` in any state: next state is IDLE, no `valid_o`, `data_o` unchanged. `flush_i` together with `start_i` in IDLE: flush wins and the start is dropped.
- Reset (`rst_i = 0` at an edge), including mid-multiply: state IDLE, `data_o = 0`, `valid_o = 0`, `busy_o = 0`, internal regs 0. `stall_o` is 0 while in reset.

## Timing
- Start sampled at the edge ending cycle T.
- Non-MUL, or MUL with B = 0: DONE in cycle T+1, `valid_o` high in T+1, `stall_o` never asserted.
- MUL with the highest set bit of B at index k (0..WIDTH-1):
  - `stall_o` high in cycles T..T+k+1
  - RUN occupies cycles T+1..T+k+1, i.e. k+1 cycles
  - DONE and `valid_o` in cycle T+k+2
- Worst case (B bit WIDTH-1 set): `valid_o` at T+WIDTH+1.
- Back-to-back: the earliest next start is sampled in the cycle after DONE (IDLE).
- Single-cycle throughput for non-MUL sequences: IDLE, DONE, IDLE… means at most one result every 2 cycles. The pipeline controller accepts this; `stall_o` is not asserted for it.

## Test plan
- Reset: hold `rst_i = 0` for 2 cycles with random inputs → `data_o = 0`, `valid_o = 0`, `stall_o = 0`, `busy_o = 0`. Release, idle 3 cycles → no `valid_o`.
- Single-cycle ops:
  - ADD with A = 0xFFFFFFFF, B = 2 → `data_o = 0x00000001`, `valid_o` at T+1
  - SUB with A = 0, B = 1 → `0xFFFFFFFF`
  - OR with A = 0xF0, B = 0x0F → `0xFF`
  - AND with A = 0xF0, B = 0x3C → `0x30`
  - `stall_o` stays 0 throughout.
- MUL early-out:
  - A = 7, B = 6 (k = 2) → `stall_o` high T..T+3, `valid_o` at T+4, `data_o = 42`
  - A = 5, B = 0 → `valid_o` at T+1, `data_o = 0`, no stall
- MUL worst case and wrap: A = 0xFFFFFFFF, B = 0x80000001 → `valid_o` at T+33, `data_o = 0x7FFFFFFF`. `start_i` held high throughout causes no re-trigger.
- Flush mid-MUL: A = 3, B = 0xFF; assert `flush_i` in cycle T+4 → IDLE at T+5, no `valid_o` ever, `data_o` keeps its prior value, `stall_o = 0` from T+4.
- Reset mid-MUL: A = 9, B = 0x100; drop `rst_i` at T+3 → IDLE, `data_o = 0`. Then a fresh MUL with A = 9, B = 3 → `data_o = 27` at T'+3.
